regfile: RTL and testbench

- 32-entry, 64-bit architectural register file for the single-cycle datapath.
- Storage stage that directly feeds the read-select mux trees. Each read port is a mux32_1 per bit, built from mux8_1 and mux4/mux2_1.
- One synchronous write port and two combinational read ports.
- Register 31 is hard-wired zero.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/register_en.sv | 33 +++
 rtl/regfile.sv | 62 ++++++
 tb/tb_regfile.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the architectural register file
package regfile_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/register_en.sv
// rtl/register_en.sv - WIDTH-bit register with load enable and synchronous active-high clear
module register_en #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Enable feedback: hold the current value unless loading.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x64 register file, one write and two combinational read ports; REGFILE_BYPASS_EN enables write-through forwarding
module regfile #(
    parameter int WIDTH    = regfile_pkg::REG_WIDTH,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [4:0]           WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic [4:0]           ReadRegister1,
    input  logic [4:0]           ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2
);

    logic [3:0]          grp_en;
    logic [7:0]          low_dec;
    logic [NUM_REGS-1:0] wr_en;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic                unused_zero_en;

    // 5:32 decode as a RegWrite-gated 2:4 selecting one of four 3:8 decoders.
    always_comb begin
        grp_en  = '0;
        low_dec = 8'b1 << WriteRegister[2:0];
        if (RegWrite) begin
            grp_en = 4'b1 << WriteRegister[4:3];
        end
        for (int g = 0; g < 4; g++) begin
            wr_en[g*8 +: 8] = grp_en[g] ? low_dec : 8'b0;
        end
    end

    assign unused_zero_en = wr_en[ZERO_REG];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        if (i == ZERO_REG) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            register_en #(.WIDTH(WIDTH)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en_i  (wr_en[i]),
                .d_i   (WriteData),
                .q_o   (regs[i])
            );
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok    = RegWrite && !reset && (WriteRegister != 5'(ZERO_REG));
    assign ReadData1 = (fwd_ok && ReadRegister1 == WriteRegister) ? WriteData : regs[ReadRegister1];
    assign ReadData2 = (fwd_ok && ReadRegister2 == WriteRegister) ? WriteData : regs[ReadRegister2];
`else
    assign ReadData1 = regs[ReadRegister1];
    assign ReadData2 = regs[ReadRegister2];
`endif

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - self-checking bench for regfile: directed table, corner sequences, random vs model
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] BASE = 64'h0123_4567_89AB_CD00;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    logic [63:0] model [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [4:0] ra);
        logic [63:0] v;
        v = (ra == 5'd31) ? 64'h0 : model[ra];
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && !reset && ra == WriteRegister && WriteRegister != 5'd31) v = WriteData;
`endif
        return v;
    endfunction

    initial begin
        vec_t vecs[5];
        logic [63:0] exp_pre;

        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'h55;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        tick();
        reset = 1'b0; RegWrite = 1'b0;

        // Reset state on every address, both ports
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            check($sformatf("reset_rd1[%0d]", a), ReadData1, 64'h0);
            check($sformatf("reset_rd2[%0d]", 31 - a), ReadData2, 64'h0);
        end

        for (int k = 0; k < 31; k++) begin
            RegWrite = 1'b1; WriteRegister = 5'(k); WriteData = BASE + 64'(k);
            tick();
        end
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(a);
            #1;
            check($sformatf("wr_rd1[%0d]", a), ReadData1, (a == 31) ? 64'h0 : BASE + 64'(a));
            check($sformatf("wr_rd2[%0d]", a), ReadData2, (a == 31) ? 64'h0 : BASE + 64'(a));
        end

        vecs[0] = '{"zero_write", 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'h0, 64'h0};
        vecs[1] = '{"we_off", 1'b0, 1'b0, 5'd5, 64'hDEAD_BEEF_DEAD_BEEF, 5'd5, 5'd31, BASE + 64'd5, 64'h0};
        vecs[2] = '{"set_r7", 1'b0, 1'b1, 5'd7, 64'h11, 5'd7, 5'd6, 64'h11, BASE + 64'd6};
        vecs[3] = '{"set_r3", 1'b0, 1'b1, 5'd3, 64'h33, 5'd3, 5'd7, 64'h33, 64'h11};
        vecs[4] = '{"rst_over_wr", 1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd3, 64'h0, 64'h0};
        for (int i = 0; i < 5; i++) begin
            reset = vecs[i].rst; RegWrite = vecs[i].we;
            WriteRegister = vecs[i].wa; WriteData = vecs[i].wd;
            tick();
            reset = 1'b0; RegWrite = 1'b0;
            ReadRegister1 = vecs[i].ra1; ReadRegister2 = vecs[i].ra2;
            #1;
            check({vecs[i].name, "_rd1"}, ReadData1, vecs[i].exp1);
            check({vecs[i].name, "_rd2"}, ReadData2, vecs[i].exp2);
        end

        // Same-cycle read/write of reg 7 after reset cleared everything
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h11;
        tick();
        WriteData = 64'h22; ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 64'h22;
`else
        exp_pre = 64'h11;
`endif
        check("rw7_pre_rd1", ReadData1, exp_pre);
        check("rw7_pre_rd2", ReadData2, exp_pre);
        tick();
        check("rw7_post_rd1", ReadData1, 64'h22);
        check("rw7_post_rd2", ReadData2, 64'h22);

        // Writing the zero register never forwards
        WriteRegister = 5'd31; WriteData = 64'hFFFF; ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        #1;
        check("zero_pre_rd1", ReadData1, 64'h0);
        check("zero_pre_rd2", ReadData2, 64'h0);
        RegWrite = 1'b0;
        tick();

        for (int a = 0; a < 32; a++) model[a] = 64'h0;
        model[7] = 64'h22;
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 39) == 0);
            RegWrite      = $urandom_range(0, 1) == 1;
            WriteRegister = 5'($urandom_range(0, 31));
            WriteData     = {$urandom, $urandom};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
            #1;
            check("rand_rd1", ReadData1, model_read(ReadRegister1));
            check("rand_rd2", ReadData2, model_read(ReadRegister2));
            if (reset) begin
                for (int a = 0; a < 32; a++) model[a] = 64'h0;
            end else if (RegWrite && WriteRegister != 5'd31) begin
                model[WriteRegister] = WriteData;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
